// File: rtl/score_disp_pkg.sv
// Shared types and constants for the score display: the converter state
// encoding and the active-low seven-segment glyph table.
package score_disp_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [6:0] BLANK = 7'b1111111;

    // Segment codes {g,f,e,d,c,b,a}, active-low; entry n is the glyph for hex digit n.
    localparam logic [15:0][6:0] SEG_TABLE = {
        7'b0001110,  // F
        7'b0000110,  // E
        7'b0100001,  // d
        7'b1000110,  // C
        7'b0000011,  // b
        7'b0001000,  // A
        7'b0010000,  // 9
        7'b0000000,  // 8
        7'b1111000,  // 7
        7'b0000010,  // 6
        7'b0010010,  // 5
        7'b0011001,  // 4
        7'b0110000,  // 3
        7'b0100100,  // 2
        7'b1111001,  // 1
        7'b1000000   // 0
    };

endpackage

// File: rtl/score_display_bin2bcd_seq.sv
// Sequential double-dabble converter: 16-bit binary to 5 BCD digits,
// one shift-add-3 iteration per clock; bcd is valid while done is high.
module bin2bcd_seq
    import score_disp_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] bin,
    output logic        busy,
    output logic        done,
    output logic [19:0] bcd
);

    state_t      state_q, state_d;
    logic [15:0] bin_q, bin_d;
    logic [19:0] bcd_q, bcd_d;
    logic [4:0]  cnt_q, cnt_d;
    logic        busy_q, busy_d;
    logic [19:0] bcd_adj;

    genvar gi;
    generate
        for (gi = 0; gi < 5; gi++) begin : g_adj
            assign bcd_adj[gi*4 +: 4] = (bcd_q[gi*4 +: 4] >= 4'd5) ?
                                        bcd_q[gi*4 +: 4] + 4'd3 : bcd_q[gi*4 +: 4];
        end
    endgenerate

    always_comb begin
        state_d = state_q;
        bin_d   = bin_q;
        bcd_d   = bcd_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    bin_d   = bin;
                    bcd_d   = '0;
                    cnt_d   = 5'd16;
                    busy_d  = 1'b1;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                {bcd_d, bin_d} = {bcd_adj[18:0], bin_q, 1'b0};
                cnt_d          = cnt_q - 5'd1;
                if (cnt_q == 5'd1) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            bin_q   <= '0;
            bcd_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            bin_q   <= bin_d;
            bcd_q   <= bcd_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
        end
    end

    assign busy = busy_q;
    assign done = (state_q == DONE);
    assign bcd  = bcd_q;

endmodule

// File: rtl/score_display.sv
// Four-digit multiplexed seven-segment score display: decimal via the
// sequential converter (clamped to 9999 with dp flag) or raw hex nibbles.
module score_display
    import score_disp_pkg::*;
#(
    parameter int SCAN_DIV = 50000,
    parameter int WIDTH    = 16
)
(
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] scr,
    input  logic             hex_mode,
    output logic [3:0]       an,
    output logic [6:0]       seg,
    output logic             dp,
    output logic             busy
);

    localparam int                CNT_W   = $clog2(SCAN_DIV);
    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(SCAN_DIV - 1);

    logic [WIDTH-1:0] last_scr_q, last_scr_d;
    logic             force_conv_q, force_conv_d;
    logic             hex_prev_q, hex_prev_d;
    logic [3:0][3:0]  digits_q, digits_d;
    logic             ovf_q, ovf_d;
    logic             hex_q, hex_d;
    logic [CNT_W-1:0] scan_cnt_q, scan_cnt_d;
    logic [1:0]       idx_q, idx_d;
    logic [3:0]       an_q, an_d;
    logic [6:0]       seg_q, seg_d;
    logic             dp_q, dp_d;

    logic             hex_fall;
    logic             conv_start;
    logic             conv_busy;
    logic             conv_done;
    logic [19:0]      conv_bcd;
    logic [3:0]       blank;

    // Leaving hex mode starts a conversion at once so decimal digits return promptly.
    assign hex_fall   = hex_prev_q & ~hex_mode;
    assign conv_start = (scr != last_scr_q) | force_conv_q | hex_fall;

    bin2bcd_seq u_conv (
        .clk   (clk),
        .rst   (rst),
        .start (conv_start),
        .bin   (scr),
        .busy  (conv_busy),
        .done  (conv_done),
        .bcd   (conv_bcd)
    );

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_blank
            if (gi == 0) begin : g_lsd
                assign blank[gi] = 1'b0;
            end else begin : g_upper
                assign blank[gi] = ~hex_q & ~|digits_q[3:gi];
            end
        end
    endgenerate

    always_comb begin
        last_scr_d   = last_scr_q;
        force_conv_d = force_conv_q;
        hex_prev_d   = hex_mode;
        digits_d     = digits_q;
        ovf_d        = ovf_q;
        hex_d        = hex_q;
        scan_cnt_d   = scan_cnt_q + CNT_W'(1);
        idx_d        = idx_q;

        if (conv_start && !conv_busy) begin
            last_scr_d   = scr;
            force_conv_d = 1'b0;
        end else if (hex_fall) begin
            force_conv_d = 1'b1;
        end

        if (hex_mode) begin
            digits_d = {scr[15:12], scr[11:8], scr[7:4], scr[3:0]};
            ovf_d    = 1'b0;
            hex_d    = 1'b1;
        end else if (conv_done) begin
            hex_d = 1'b0;
            if (conv_bcd[19:16] != 4'd0) begin
                digits_d = {4{4'd9}};
                ovf_d    = 1'b1;
            end else begin
                digits_d = conv_bcd[15:0];
                ovf_d    = 1'b0;
            end
        end

        if (scan_cnt_q == CNT_MAX) begin
            scan_cnt_d = '0;
            idx_d      = idx_q + 2'd1;
        end

        an_d  = ~(4'b0001 << idx_q);
        seg_d = blank[idx_q] ? BLANK : SEG_TABLE[digits_q[idx_q]];
        dp_d  = ~((idx_q == 2'd3) & ovf_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_scr_q   <= '0;
            force_conv_q <= 1'b1;
            hex_prev_q   <= 1'b0;
            digits_q     <= '0;
            ovf_q        <= 1'b0;
            hex_q        <= 1'b0;
            scan_cnt_q   <= '0;
            idx_q        <= '0;
            an_q         <= 4'b1111;
            seg_q        <= BLANK;
            dp_q         <= 1'b1;
        end else begin
            last_scr_q   <= last_scr_d;
            force_conv_q <= force_conv_d;
            hex_prev_q   <= hex_prev_d;
            digits_q     <= digits_d;
            ovf_q        <= ovf_d;
            hex_q        <= hex_d;
            scan_cnt_q   <= scan_cnt_d;
            idx_q        <= idx_d;
            an_q         <= an_d;
            seg_q        <= seg_d;
            dp_q         <= dp_d;
        end
    end

    assign an   = an_q;
    assign seg  = seg_q;
    assign dp   = dp_q;
    assign busy = conv_busy;

endmodule

// File: tb/tb_score_display.sv
// Directed self-checking bench for score_display with a 4-cycle scan period.
module tb_score_display;

    localparam logic [6:0] S0 = 7'b1000000, S1 = 7'b1111001, S2 = 7'b0100100;
    localparam logic [6:0] S3 = 7'b0110000, S4 = 7'b0011001, S5 = 7'b0010010;
    localparam logic [6:0] S6 = 7'b0000010, S7 = 7'b1111000, S9 = 7'b0010000;
    localparam logic [6:0] SA = 7'b0001000, SB = 7'b1111111;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] scr;
    logic        hex_mode;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic        busy;

    int checks = 0;
    int fails  = 0;

    logic [6:0] seg_at [4];
    logic       dp_at  [4];
    int         cnt_at [4];
    int         bad_an;

    score_display #(.SCAN_DIV(4), .WIDTH(16)) dut (
        .clk      (clk),
        .rst      (rst),
        .scr      (scr),
        .hex_mode (hex_mode),
        .an       (an),
        .seg      (seg),
        .dp       (dp),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Watches one full 16-cycle scan and records what each anode showed.
    task automatic capture();
        int k;
        for (int i = 0; i < 4; i++) cnt_at[i] = 0;
        bad_an = 0;
        for (int c = 0; c < 16; c++) begin
            tick(1);
            k = -1;
            case (an)
                4'b1110: k = 0;
                4'b1101: k = 1;
                4'b1011: k = 2;
                4'b0111: k = 3;
                default: bad_an++;
            endcase
            if (k >= 0) begin
                seg_at[k] = seg;
                dp_at[k]  = dp;
                cnt_at[k]++;
            end
        end
    endtask

    task automatic test_reset();
        logic [3:0][6:0] es;
        $display("reset: rst held 3 cycles, then scr=0 decimal");
        rst = 1'b1; scr = 16'd0; hex_mode = 1'b0;
        tick(3);
        checks++; if (an !== 4'b1111) begin fails++; $display("FAIL reset_an: got %b expected 1111", an); end
        checks++; if (seg !== SB) begin fails++; $display("FAIL reset_seg: got %b expected %b", seg, SB); end
        checks++; if (dp !== 1'b1) begin fails++; $display("FAIL reset_dp: got %b expected 1", dp); end
        checks++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b expected 0", busy); end
        rst = 1'b0;
        tick(1);
        checks++; if (busy !== 1'b1) begin fails++; $display("FAIL reset_busy_start: got %b expected 1", busy); end
        tick(16);
        checks++; if (busy !== 1'b1) begin fails++; $display("FAIL reset_busy_c17: got %b expected 1", busy); end
        tick(1);
        checks++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy_c18: got %b expected 0", busy); end
        capture();
        es = {SB, SB, SB, S0};
        for (int i = 0; i < 4; i++) begin
            checks++; if (seg_at[i] !== es[i]) begin fails++; $display("FAIL zero_seg%0d: got %b expected %b", i, seg_at[i], es[i]); end
            checks++; if (dp_at[i] !== 1'b1) begin fails++; $display("FAIL zero_dp%0d: got %b expected 1", i, dp_at[i]); end
            checks++; if (cnt_at[i] !== 4) begin fails++; $display("FAIL zero_dwell%0d: got %0d expected 4", i, cnt_at[i]); end
        end
        checks++; if (bad_an !== 0) begin fails++; $display("FAIL zero_onehot: got %0d bad anode cycles expected 0", bad_an); end
    endtask

    task automatic test_decimal();
        logic [3:0][6:0] es;
        $display("decimal: scr=1234");
        scr = 16'd1234;
        tick(17);
        checks++; if (busy !== 1'b1) begin fails++; $display("FAIL dec_busy_c17: got %b expected 1", busy); end
        tick(1);
        checks++; if (busy !== 1'b0) begin fails++; $display("FAIL dec_busy_c18: got %b expected 0", busy); end
        capture();
        es = {S1, S2, S3, S4};
        for (int i = 0; i < 4; i++) begin
            checks++; if (seg_at[i] !== es[i]) begin fails++; $display("FAIL dec_seg%0d: got %b expected %b", i, seg_at[i], es[i]); end
            checks++; if (cnt_at[i] !== 4) begin fails++; $display("FAIL dec_dwell%0d: got %0d expected 4", i, cnt_at[i]); end
        end
        checks++; if (bad_an !== 0) begin fails++; $display("FAIL dec_onehot: got %0d bad anode cycles expected 0", bad_an); end
    endtask

    task automatic test_overflow();
        logic [15:0] vals [3];
        logic [3:0]  edp  [3];
        vals = '{16'd9999, 16'd10000, 16'd12345};
        edp  = '{4'b1111, 4'b0111, 4'b0111};
        for (int v = 0; v < 3; v++) begin
            $display("overflow: scr=%0d", vals[v]);
            scr = vals[v];
            tick(18);
            capture();
            for (int i = 0; i < 4; i++) begin
                checks++; if (seg_at[i] !== S9) begin fails++; $display("FAIL ovf_seg%0d scr=%0d: got %b expected %b", i, vals[v], seg_at[i], S9); end
                checks++; if (dp_at[i] !== edp[v][i]) begin fails++; $display("FAIL ovf_dp%0d scr=%0d: got %b expected %b", i, vals[v], dp_at[i], edp[v][i]); end
            end
        end
    endtask

    task automatic test_hex();
        logic [3:0][6:0] es;
        $display("hex: scr=16'h0040, no blanking");
        hex_mode = 1'b1; scr = 16'h0040;
        tick(1);
        capture();
        es = {S0, S0, S4, S0};
        for (int i = 0; i < 4; i++) begin
            checks++; if (seg_at[i] !== es[i]) begin fails++; $display("FAIL hex0040_seg%0d: got %b expected %b", i, seg_at[i], es[i]); end
            checks++; if (dp_at[i] !== 1'b1) begin fails++; $display("FAIL hex0040_dp%0d: got %b expected 1", i, dp_at[i]); end
        end
        tick(4);
        $display("hex: scr=16'h1A35, background conversion must stay hidden");
        scr = 16'h1A35;
        tick(10);
        capture();
        es = {S1, SA, S3, S5};
        for (int i = 0; i < 4; i++) begin
            checks++; if (seg_at[i] !== es[i]) begin fails++; $display("FAIL hex1a35_seg%0d: got %b expected %b", i, seg_at[i], es[i]); end
        end
        $display("hex: hex_mode 1->0 with scr unchanged, expect 6709");
        hex_mode = 1'b0;
        tick(18);
        checks++; if (busy !== 1'b0) begin fails++; $display("FAIL hexoff_busy: got %b expected 0", busy); end
        capture();
        es = {S6, S7, S0, S9};
        for (int i = 0; i < 4; i++) begin
            checks++; if (seg_at[i] !== es[i]) begin fails++; $display("FAIL hexoff_seg%0d: got %b expected %b", i, seg_at[i], es[i]); end
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0][6:0] es;
        $display("back_to_back: scr=100 then scr=200 five cycles later");
        scr = 16'd100;
        tick(5);
        scr = 16'd200;
        tick(12);
        checks++; if (busy !== 1'b1) begin fails++; $display("FAIL b2b_busy_c17: got %b expected 1", busy); end
        tick(1);
        checks++; if (busy !== 1'b0) begin fails++; $display("FAIL b2b_busy_c18: got %b expected 0", busy); end
        tick(1);
        checks++; if (busy !== 1'b1) begin fails++; $display("FAIL b2b_busy_c19: got %b expected 1", busy); end
        capture();
        es = {SB, S1, S0, S0};
        for (int i = 0; i < 4; i++) begin
            checks++; if (seg_at[i] !== es[i]) begin fails++; $display("FAIL b2b_100_seg%0d: got %b expected %b", i, seg_at[i], es[i]); end
        end
        tick(1);
        checks++; if (busy !== 1'b0) begin fails++; $display("FAIL b2b_busy_c36: got %b expected 0", busy); end
        capture();
        es = {SB, S2, S0, S0};
        for (int i = 0; i < 4; i++) begin
            checks++; if (seg_at[i] !== es[i]) begin fails++; $display("FAIL b2b_200_seg%0d: got %b expected %b", i, seg_at[i], es[i]); end
        end
    endtask

    task automatic test_reset_mid();
        logic [3:0][6:0] es;
        $display("reset_mid: scr=555, rst pulse during SHIFT");
        scr = 16'd555;
        tick(5);
        rst = 1'b1;
        tick(1);
        checks++; if (an !== 4'b1111) begin fails++; $display("FAIL rmid_an: got %b expected 1111", an); end
        checks++; if (seg !== SB) begin fails++; $display("FAIL rmid_seg: got %b expected %b", seg, SB); end
        checks++; if (dp !== 1'b1) begin fails++; $display("FAIL rmid_dp: got %b expected 1", dp); end
        checks++; if (busy !== 1'b0) begin fails++; $display("FAIL rmid_busy: got %b expected 0", busy); end
        rst = 1'b0;
        tick(1);
        checks++; if (busy !== 1'b1) begin fails++; $display("FAIL rmid_restart: got %b expected 1", busy); end
        tick(17);
        checks++; if (busy !== 1'b0) begin fails++; $display("FAIL rmid_busy_c18: got %b expected 0", busy); end
        capture();
        es = {SB, S5, S5, S5};
        for (int i = 0; i < 4; i++) begin
            checks++; if (seg_at[i] !== es[i]) begin fails++; $display("FAIL rmid_seg%0d: got %b expected %b", i, seg_at[i], es[i]); end
        end
    endtask

    initial begin
        test_reset();
        test_decimal();
        test_overflow();
        test_hex();
        test_back_to_back();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
